control_ascensor: RTL and testbench
===================================

Name: control_ascensor

Overview:
Elevator car controller. It sits directly downstream of the request registrar and closes that loop.
- Registers the merged request vector (solicitudes_final), holds it as the pending set, clears floors as they are served, and returns the result as solicitudes_inicial to the registrar.
- Runs a collective-scan state machine that moves the car floor by floor, opens the door at requested floors and idles when nothing is pending.

Parameters:
N_PISOS, 10, number of floors; floor indices 0..N_PISOS-1.
TIEMPO_PISO, 50, clock cycles to travel one floor (>=1).
TIEMPO_PUERTA, 100, clock cycles the door stays open (>=1).

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
solicitudes_final  in  N_PISOS  merged requests from registrar (buttons OR pending)
solicitudes_inicial  out  N_PISOS  registered pending requests, served floor cleared; feeds registrar
piso_actual  out  $clog2(N_PISOS)  current floor, binary
motor_sube  out  1  car moving up
motor_baja  out  1  car moving down
puerta_abierta  out  1  door open
direccion  out  1  1 = up preference, 0 = down preference

Behaviour:
- Reset (reset_n=0 at clk edge): pending=0, piso_actual=0, state REPOSO, timer=0, direccion=1, all motor/door outputs 0. Reset mid-travel or mid-door discards all pending requests; the car stays logically at floor 0.
- Pending register updates every cycle: pending <= solicitudes_final & ~servido.
  - servido is the one-hot of piso_actual while state==PUERTA, else 0.
  - solicitudes_inicial = pending, so there is 1-cycle latency from button to pending.
- Terminology: arriba = |pending above piso_actual; abajo = |pending below; aqui = pending[piso_actual].
- States are REPOSO, SUBIENDO, BAJANDO, PUERTA. Outputs are decoded from state: motor_sube=SUBIENDO, motor_baja=BAJANDO, puerta_abierta=PUERTA.
- Decision function, used in REPOSO and on door expiry, in priority order:
  - aqui (REPOSO only) -> PUERTA.
  - direccion=1 & arriba -> SUBIENDO.
  - direccion=0 & abajo -> BAJANDO.
  - arriba -> SUBIENDO, direccion=1.
  - abajo -> BAJANDO, direccion=0.
  - else -> REPOSO (direccion holds).
- Timer loading: entering SUBIENDO/BAJANDO loads timer=TIEMPO_PISO-1; entering PUERTA loads timer=TIEMPO_PUERTA-1.
- SUBIENDO/BAJANDO:
  - Timer decrements each cycle. At 0, piso_actual increments or decrements by 1.
  - If the new floor is pending -> PUERTA. Else stay in the same motion state and reload the timer.
  - Pending requests are never withdrawn, so a move always has a target. The car never goes above N_PISOS-1 or below 0; the decision function guarantees this.
- PUERTA:
  - Timer decrements. At 0, apply the decision function with aqui ignored.
  - A new press of the current floor during PUERTA reloads the door timer; it is detected as solicitudes_final[piso_actual]=1 in any PUERTA cycle after the first. The bit is still cleared from pending.
- Simultaneous events: requests arriving in the same cycle as a floor arrival are evaluated at the next decision point only. They do not redirect an in-progress floor transit.

Optional Feature:
Macro ASCENSOR_EMERGENCIA_EN.
- Defined:
  - Adds input port parada (1 bit). While parada=1, motor_sube/motor_baja/puerta_abierta are forced to 0, timer and state freeze, and pending keeps updating.
  - On release, operation resumes from the frozen state and timer value.
- Undefined: no port; behaviour as above.

Decomposition:
- Shared package pkg_ascensor holds:
  - the state enum (REPOSO, SUBIENDO, BAJANDO, PUERTA);
  - N_PISOS default;
  - the floor-index width constant.
- One natural sub-module, temporizador_ascensor: a loadable down-counter with load value, enable and zero flag, shared by the travel and door timing.

Test Plan:
1. TIEMPO_PISO=4, TIEMPO_PUERTA=3; after reset, pulse bit 5 for one cycle -> solicitudes_inicial[5]=1 next cycle; motor_sube for 20 cycles; piso_actual=5; puerta_abierta 3 cycles; bit 5 clears; REPOSO.
2. At floor 0, request floors 3 and 7; while passing floor 2, request floor 1 -> stops at 3 then 7 (up); then direccion=0, travels down and stops at 1.
3. In REPOSO at floor 4, press 4 -> PUERTA next cycle; no motor cycles; bit 4 never persists past the door state.
4. During PUERTA at floor 2 (TIEMPO_PUERTA=3), press 2 again at door cycle 2 -> door stays open 3 further cycles from the press.
5. Assert reset_n=0 mid-travel between floors 3 and 4 with requests {6,8} -> next cycle: piso_actual=0, pending=0, all outputs 0, REPOSO.
6. With ASCENSOR_EMERGENCIA_EN: assert parada for 10 cycles mid-travel -> motor_sube=0 and piso_actual unchanged; after release, arrival is delayed by exactly 10 cycles.

Source files
------------

// File: rtl/control_ascensor_pkg.sv
// rtl/control_ascensor_pkg.sv - shared types and sizing helpers for the elevator controller
package pkg_ascensor;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estado_t;

  localparam int N_PISOS_DEF = 10;

  // Width needed to index n items; never below one bit.
  function automatic int ancho(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ancho_cuenta(input int a, input int b);
    return ancho((a > b) ? a : b);
  endfunction

  localparam int PISO_W = ancho(N_PISOS_DEF);

endpackage

// File: rtl/temporizador_ascensor.sv
// rtl/temporizador_ascensor.sv - loadable down-counter shared by travel and door timing
module temporizador_ascensor #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             carga_i,
  input  logic [ANCHO-1:0] valor_i,
  input  logic             habilita_i,
  output logic             cero_o
);

  localparam logic [ANCHO-1:0] UNO = {{(ANCHO-1){1'b0}}, 1'b1};

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  // Load wins over decrement; the count parks at zero until reloaded.
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (habilita_i && (cuenta_q != '0)) begin
      cuenta_d = cuenta_q - UNO;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cero_o = (cuenta_q == '0);

endmodule

// File: rtl/control_ascensor.sv
// rtl/control_ascensor.sv - collective-scan elevator car controller; ASCENSOR_EMERGENCIA_EN adds the parada stop input
module control_ascensor
  import pkg_ascensor::*;
#(
  parameter int N_PISOS       = N_PISOS_DEF,
  parameter int TIEMPO_PISO   = 50,
  parameter int TIEMPO_PUERTA = 100
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef ASCENSOR_EMERGENCIA_EN
  input  logic                       parada,
`endif
  input  logic [N_PISOS-1:0]         solicitudes_final,
  output logic [N_PISOS-1:0]         solicitudes_inicial,
  output logic [ancho(N_PISOS)-1:0]  piso_actual,
  output logic                       motor_sube,
  output logic                       motor_baja,
  output logic                       puerta_abierta,
  output logic                       direccion
);

  localparam int PW = ancho(N_PISOS);
  localparam int TW = ancho_cuenta(TIEMPO_PISO, TIEMPO_PUERTA);
  localparam logic [PW-1:0] PISO_UNO  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] T_PISO    = TW'(TIEMPO_PISO - 1);
  localparam logic [TW-1:0] T_PUERTA  = TW'(TIEMPO_PUERTA - 1);

  logic congelado;
`ifdef ASCENSOR_EMERGENCIA_EN
  assign congelado = parada;
`else
  assign congelado = 1'b0;
`endif

  estado_t           estado_q, estado_d;
  logic [PW-1:0]     piso_q, piso_d;
  logic              dir_q, dir_d;
  logic              prev_puerta_q;
  logic [N_PISOS-1:0] pend_q, pend_d, servido;

  logic              arriba, abajo, aqui;
  estado_t           dec_estado;
  logic              dec_dir;
  logic              carga;
  logic [TW-1:0]     valor;
  logic              cero;

  always_comb begin
    arriba  = 1'b0;
    abajo   = 1'b0;
    servido = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (i > int'(piso_q)) arriba = arriba | pend_q[i];
      if (i < int'(piso_q)) abajo  = abajo  | pend_q[i];
      if ((estado_q == PUERTA) && (i == int'(piso_q))) servido[i] = 1'b1;
    end
  end

  assign aqui   = pend_q[piso_q];
  assign pend_d = solicitudes_final & ~servido;

  // Keep going the current way while there is work that way; otherwise turn.
  always_comb begin
    dec_estado = REPOSO;
    dec_dir    = dir_q;
    if (dir_q && arriba) begin
      dec_estado = SUBIENDO;
    end else if (!dir_q && abajo) begin
      dec_estado = BAJANDO;
    end else if (arriba) begin
      dec_estado = SUBIENDO;
      dec_dir    = 1'b1;
    end else if (abajo) begin
      dec_estado = BAJANDO;
      dec_dir    = 1'b0;
    end
  end

  always_comb begin
    estado_d = estado_q;
    piso_d   = piso_q;
    dir_d    = dir_q;
    carga    = 1'b0;
    valor    = T_PISO;
    case (estado_q)
      REPOSO: begin
        if (aqui) begin
          estado_d = PUERTA;
          carga    = 1'b1;
          valor    = T_PUERTA;
        end else begin
          estado_d = dec_estado;
          dir_d    = dec_dir;
          carga    = (dec_estado != REPOSO);
        end
      end
      SUBIENDO, BAJANDO: begin
        if (cero) begin
          piso_d = (estado_q == SUBIENDO) ? piso_q + PISO_UNO : piso_q - PISO_UNO;
          carga  = 1'b1;
          // Only requests already registered can stop the car at the new floor.
          if (pend_q[piso_d]) begin
            estado_d = PUERTA;
            valor    = T_PUERTA;
          end
        end
      end
      PUERTA: begin
        if (prev_puerta_q && solicitudes_final[piso_q]) begin
          carga = 1'b1;
          valor = T_PUERTA;
        end else if (cero) begin
          estado_d = dec_estado;
          dir_d    = dec_dir;
          carga    = (dec_estado != REPOSO);
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  temporizador_ascensor #(
    .ANCHO (TW)
  ) u_temporizador (
    .clk        (clk),
    .reset_n    (reset_n),
    .carga_i    (carga & ~congelado),
    .valor_i    (valor),
    .habilita_i (~congelado),
    .cero_o     (cero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q        <= '0;
      piso_q        <= '0;
      estado_q      <= REPOSO;
      dir_q         <= 1'b1;
      prev_puerta_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (!congelado) begin
        estado_q      <= estado_d;
        piso_q        <= piso_d;
        dir_q         <= dir_d;
        prev_puerta_q <= (estado_q == PUERTA);
      end
    end
  end

  assign solicitudes_inicial = pend_q;
  assign piso_actual         = piso_q;
  assign direccion           = dir_q;
  assign motor_sube          = (estado_q == SUBIENDO) & ~congelado;
  assign motor_baja          = (estado_q == BAJANDO)  & ~congelado;
  assign puerta_abierta      = (estado_q == PUERTA)   & ~congelado;

endmodule

// File: tb/tb_control_ascensor.sv
// tb/tb_control_ascensor.sv - self-checking bench for control_ascensor with a registrar feedback model
module tb_control_ascensor;

  localparam int NP = 10;
  localparam int TP = 4;
  localparam int TD = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NP-1:0] botones;
  logic [NP-1:0] sol_final;
  logic [NP-1:0] sol_ini;
  logic [3:0]    piso;
  logic          sube, baja, puerta, dir;
`ifdef ASCENSOR_EMERGENCIA_EN
  logic          parada;
`endif

  always #5 clk = ~clk;

  // Registrar: merged vector is fresh presses OR what is still pending.
  assign sol_final = botones | sol_ini;

  control_ascensor #(
    .N_PISOS       (NP),
    .TIEMPO_PISO   (TP),
    .TIEMPO_PUERTA (TD)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
`ifdef ASCENSOR_EMERGENCIA_EN
    .parada              (parada),
`endif
    .solicitudes_final   (sol_final),
    .solicitudes_inicial (sol_ini),
    .piso_actual         (piso),
    .motor_sube          (sube),
    .motor_baja          (baja),
    .puerta_abierta      (puerta),
    .direccion           (dir)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int piso; int lat;} esperado_t;
  typedef struct {int destino; int latencia; int motor; int puerta;} vec_t;
  esperado_t cola[$];
  vec_t      tabla[4];

  task automatic paso();
    @(negedge clk);
  endtask

  task automatic chk(input string nombre, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nombre, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    botones = '0;
    paso();
    paso();
    reset_n = 1'b1;
  endtask

  task automatic pulsar(input int f);
    botones    = '0;
    botones[f] = 1'b1;
    paso();
    botones    = '0;
  endtask

  task automatic esperar_puerta(input int limite, output int lat, output int motor);
    lat   = 0;
    motor = 0;
    while (!puerta && lat < limite) begin
      if (sube || baja) motor++;
      paso();
      lat++;
    end
    if (!puerta) chk("timeout_puerta", int'(puerta), 1);
  endtask

  task automatic contar_puerta(output int d);
    d = 0;
    while (puerta && d < 100) begin
      d++;
      paso();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, motor, d, bad, cyc, p0;
    bit pulsado, prev;
    esperado_t e;

    botones = '0;
`ifdef ASCENSOR_EMERGENCIA_EN
    parada = 1'b0;
`endif
    tabla[0] = '{0, TP * 0 + 1, 0,      TD};
    tabla[1] = '{1, TP * 1 + 1, TP * 1, TD};
    tabla[2] = '{5, TP * 5 + 1, TP * 5, TD};
    tabla[3] = '{9, TP * 9 + 1, TP * 9, TD};

    do_reset();
    chk("reset_piso",   int'(piso),    0);
    chk("reset_pend",   int'(sol_ini), 0);
    chk("reset_motor",  int'(sube | baja), 0);
    chk("reset_puerta", int'(puerta),  0);
    chk("reset_dir",    int'(dir),     1);

    // Single trips from reset, one table row each.
    foreach (tabla[i]) begin
      do_reset();
      pulsar(tabla[i].destino);
      chk("pend_un_ciclo", int'(sol_ini[tabla[i].destino]), 1);
      cola.push_back('{tabla[i].destino, tabla[i].latencia});
      esperar_puerta(500, lat, motor);
      e = cola.pop_front();
      chk("viaje_piso",     int'(piso), e.piso);
      chk("viaje_latencia", lat,        e.lat);
      chk("viaje_motor",    motor,      tabla[i].motor);
      contar_puerta(d);
      chk("viaje_puerta",   d,          tabla[i].puerta);
      chk("viaje_borrado",  int'(sol_ini[tabla[i].destino]), 0);
      chk("viaje_reposo",   int'(sube | baja | puerta), 0);
    end

    // Stops 3 and 7 going up, then floor 1 on the way down.
    do_reset();
    botones[3] = 1'b1;
    botones[7] = 1'b1;
    paso();
    botones = '0;
    cola.push_back('{3, 0});
    cola.push_back('{7, 0});
    cyc = 0;
    pulsado = 1'b0;
    prev = 1'b0;
    while (cyc < 2000 && (cola.size() > 0 || puerta || sube || baja)) begin
      botones = '0;
      if (!pulsado && piso == 4'd2 && sube) begin
        botones[1] = 1'b1;
        pulsado = 1'b1;
        cola.push_back('{1, 0});
      end
      if (puerta && !prev) begin
        if (cola.size() == 0) begin
          chk("parada_extra", int'(piso), -1);
        end else begin
          e = cola.pop_front();
          chk("orden_paradas", int'(piso), e.piso);
          chk("dir_parada",    int'(dir),  (e.piso == 1) ? 0 : 1);
        end
      end
      prev = puerta;
      paso();
      cyc++;
    end
    botones = '0;
    chk("scan_pulsado",    int'(pulsado), 1);
    chk("scan_cola_vacia", cola.size(),   0);
    chk("scan_piso_final", int'(piso),    1);

    // Press the floor the idle car is standing on.
    pulsar(4);
    esperar_puerta(500, lat, motor);
    contar_puerta(d);
    chk("aqui_piso", int'(piso), 4);
    pulsar(4);
    chk("aqui_aun_cerrada", int'(puerta), 0);
    paso();
    chk("aqui_abre", int'(puerta), 1);
    d = 0;
    bad = 0;
    motor = 0;
    while (puerta && d < 100) begin
      if (d >= 1 && sol_ini[4]) bad++;
      if (sube || baja) motor++;
      d++;
      paso();
    end
    chk("aqui_duracion", d,     TD);
    chk("aqui_persiste", bad,   0);
    chk("aqui_motor",    motor, 0);
    chk("aqui_borrado",  int'(sol_ini[4]), 0);

    // Re-press of the current floor during the second door cycle.
    pulsar(2);
    esperar_puerta(500, lat, motor);
    chk("repulsa_piso", int'(piso), 2);
    paso();
    botones[2] = 1'b1;
    paso();
    botones = '0;
    contar_puerta(d);
    chk("repulsa_extra", d, TD);

    // Reset while travelling between floors 3 and 4.
    do_reset();
    botones[6] = 1'b1;
    botones[8] = 1'b1;
    paso();
    botones = '0;
    cyc = 0;
    while (!(piso == 4'd3 && sube) && cyc < 500) begin
      paso();
      cyc++;
    end
    chk("mid_en_piso3", int'(piso), 3);
    paso();
    paso();
    reset_n = 1'b0;
    paso();
    chk("mid_reset_piso",   int'(piso),    0);
    chk("mid_reset_pend",   int'(sol_ini), 0);
    chk("mid_reset_salida", int'(sube | baja | puerta), 0);
    chk("mid_reset_dir",    int'(dir),     1);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      paso();
      if (sube || baja || puerta || piso != 4'd0) bad++;
    end
    chk("mid_reset_quieto", bad, 0);

`ifdef ASCENSOR_EMERGENCIA_EN
    // Emergency stop for ten cycles mid-travel.
    do_reset();
    pulsar(2);
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      paso();
      lat++;
    end
    chk("emerg_en_marcha", int'(sube), 1);
    p0 = int'(piso);
    parada = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      paso();
      lat++;
      if (sube || baja || puerta) bad++;
      if (int'(piso) != p0) bad++;
    end
    parada = 1'b0;
    chk("emerg_congelado", bad, 0);
    esperar_puerta(500, d, motor);
    chk("emerg_retraso", lat + d, TP * 2 + 1 + 10);
    chk("emerg_piso",    int'(piso), 2);
`else
    p0 = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
